bnn_tray_scheduler: RTL and testbench
=====================================

BNN_TRAY_SCHEDULER -- requirements
Module: bnn_tray_scheduler

Interface
REQ-001 Parameter CONFIRM_N, default 3, range 1..7: consecutive "ready" results needed to confirm harvest for a tray.
REQ-002 Parameter TIMEOUT, default 15, range 2..255: maximum WAIT cycles before the classifier is declared hung.
REQ-003 clk  input  1  single clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ena  input  1  enable; when low, all state, counters and outputs hold.
REQ-006 req  input  4  per-tray level request; bit i set means tray i wants a classification.
REQ-007 tray_feat  input  64  tray i features at [16i+15:16i]; order is height, color, density, texture, 4 bits each, LSB first.
REQ-008 cls_start  output  1  one-cycle pulse launching the shared classifier.
REQ-009 cls_feat  output  16  features presented to the classifier.
REQ-010 cls_done  input  1  classifier result-valid pulse.
REQ-011 cls_result  input  1  classifier decision: 1 = ready to harvest.
REQ-012 grant  output  4  one-hot tray owning the classifier; zero when idle.
REQ-013 result  output  4  last committed classifier decision per tray.
REQ-014 harvest_ready  output  4  per-tray confirmed-harvest flag.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 timeout_err  output  1  sticky flag set by a classifier timeout.

Function
REQ-017 FSM states and transitions:
- IDLE -> ISSUE when any req bit is set.
- ISSUE -> WAIT unconditionally.
- WAIT -> COMMIT on cls_done, or when the timeout fires (REQ-023).
- COMMIT -> IDLE unconditionally.
REQ-018 Arbitration: round-robin in IDLE; search starts at rr_ptr and wraps 3 -> 0.
REQ-019 Arbitration update: grant and rr_ptr = granted+1 (mod 4) are registered on the IDLE -> ISSUE edge.
REQ-020 Feature capture: the granted tray's tray_feat slice is captured into cls_feat on the IDLE -> ISSUE edge and held unchanged until COMMIT exits.
REQ-021 cls_start is high for exactly the one cycle spent in ISSUE; it is never asserted elsewhere.
REQ-022 WAIT counter: cleared on entry to WAIT, incremented each enabled WAIT cycle.
REQ-023 Timeout: fires when the WAIT counter equals TIMEOUT-1 and cls_done is low. On timeout, the committed decision is 0 and timeout_err is set.
REQ-024 Simultaneous cls_done and timeout on the same cycle: cls_done wins; no error is raised.
REQ-025 cls_done outside WAIT is ignored, with no state change.
REQ-026 COMMIT updates result[g] for the granted tray g.
REQ-027 Confirm counter for tray g in COMMIT: decision 1 increments it, saturating at CONFIRM_N; decision 0 clears it.
REQ-028 harvest_ready[i] is 1 exactly when confirm counter i equals CONFIRM_N (registered).
REQ-029 Deasserting req[g] during ISSUE or WAIT does not abort the transaction; it completes and commits.
REQ-030 grant clears on the COMMIT -> IDLE edge.
REQ-031 Minimum transaction length is IDLE + ISSUE + WAIT(1) + COMMIT = 4 cycles per grant.

Reset
REQ-032 Asynchronous assertion of rst_n low forces the following, at any time including mid-transaction: state IDLE, rr_ptr 0, grant 0, cls_start 0, cls_feat 0, result 0, all confirm counters 0, harvest_ready 0, busy 0, timeout_err 0, WAIT counter 0.
REQ-033 timeout_err is cleared only by reset.

Structure
REQ-034 Shared package bnn_sched_pkg holds the following:
- FSM state enum;
- NUM_TRAYS = 4;
- FEAT_W = 16;
- confirm counter width = 3.
REQ-035 The round-robin pick is implemented as sub-module rr_arbiter4.
- Inputs: req[3:0], ptr[1:0].
- Outputs: one-hot gnt[3:0], valid.
- Purely combinational.

Verification
REQ-036 Scenario: single tray.
- Stimulus: req=0001; classifier returns done with result 1 two cycles after cls_start.
- Required: grant=0001; cls_start asserted 1 cycle after IDLE; result[0]=1; harvest_ready[0]=1 after the third commit.
REQ-037 Scenario: round-robin fairness.
- Stimulus: req=1111 held; every classifier call returns done.
- Required: grant sequence 0001, 0010, 0100, 1000, 0001; no tray is skipped.
- Required: cls_feat equals the granted slice at each cls_start.
REQ-038 Scenario: timeout.
- Stimulus: req=0100; cls_done never asserts; TIMEOUT=15.
- Required: COMMIT 15 WAIT cycles after entry; result[2]=0; timeout_err=1, which persists through later successful transactions.
REQ-039 Scenario: confirm reset.
- Stimulus: tray 1 returns results 1, 1, 0, 1, 1, 1.
- Required: harvest_ready[1] stays 0 until the sixth commit, then goes 1.
REQ-040 Scenario: boundary events.
- Stimulus: cls_done coincident with the last WAIT cycle; a stray cls_done during IDLE.
- Required: coincident done commits cls_result with no error; stray done causes no state change.
REQ-041 Scenario: reset and enable.
- Stimulus: rst_n pulsed low during WAIT; separately, ena low for 5 cycles during WAIT.
- Required: reset returns all outputs to reset values immediately.
- Required: with ena low, the WAIT counter freezes and no timeout occurs during the hold.

Source files
------------

// File: rtl/bnn_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_sched_pkg
//  Description : Shared types and constants for the BNN tray scheduler:
//                FSM state encoding, tray count, feature width, confirm
//                counter width and a one-hot to index helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bnn_sched_pkg;

    localparam int NUM_TRAYS = 4;
    localparam int FEAT_W    = 16;
    localparam int CONF_W    = 3;
    localparam int WCNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } sched_state_t;

    // Converts a one-hot tray vector to its index. Returns 0 for an all-zero
    // vector; callers only use it when the vector is known to be valid.
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_TRAYS-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_TRAYS; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter4
//  Description : Purely combinational 4-way round-robin pick. The search
//                begins at ptr and wraps 3 -> 0; the first requesting tray
//                found is granted.
//  Ports       : req[3:0]  request vector
//                ptr[1:0]  search start position
//                gnt[3:0]  one-hot grant (zero when nothing requested)
//                valid     at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter4
    import bnn_sched_pkg::*;
(
    input  logic [NUM_TRAYS-1:0] req,
    input  logic [1:0]           ptr,
    output logic [NUM_TRAYS-1:0] gnt,
    output logic                 valid
);

    always_comb begin
        logic       found;
        logic [1:0] idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_TRAYS; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        valid = found;
    end

endmodule
`default_nettype wire

// File: rtl/bnn_tray_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_tray_scheduler
//  Description : Shares one binary-neural-net classifier among four trays.
//                Trays are picked round-robin, the granted tray's features
//                are presented with a start pulse, the result (or a timeout)
//                is committed per tray, and a confirm counter per tray raises
//                harvest_ready after CONFIRM_N consecutive "ready" results.
//  Ports       : clk, rst_n (async, active low), ena (global hold)
//                req[3:0], tray_feat[63:0]          tray side
//                cls_start, cls_feat[15:0]          classifier launch
//                cls_done, cls_result               classifier response
//                grant, result, harvest_ready       per-tray status
//                busy, timeout_err                  scheduler status
//  Revision    : 1.0 - initial release
// ============================================================================
module bnn_tray_scheduler
    import bnn_sched_pkg::*;
#(
    parameter int CONFIRM_N = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic [NUM_TRAYS-1:0]        req,
    input  logic [NUM_TRAYS*FEAT_W-1:0] tray_feat,
    output logic                        cls_start,
    output logic [FEAT_W-1:0]           cls_feat,
    input  logic                        cls_done,
    input  logic                        cls_result,
    output logic [NUM_TRAYS-1:0]        grant,
    output logic [NUM_TRAYS-1:0]        result,
    output logic [NUM_TRAYS-1:0]        harvest_ready,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(CONFIRM_N);
    localparam logic [WCNT_W-1:0] TMO_LAST = WCNT_W'(TIMEOUT - 1);

    sched_state_t        state;
    logic [1:0]          rr_ptr;
    logic [1:0]          gidx;
    logic [WCNT_W-1:0]   wait_cnt;
    logic                commit_dec;
    logic [CONF_W-1:0]   conf_cnt [NUM_TRAYS];

    logic [NUM_TRAYS-1:0] arb_gnt;
    logic                 arb_valid;
    logic [1:0]           arb_idx;
    logic [FEAT_W-1:0]    feat_sel;
    logic [CONF_W-1:0]    conf_cur;
    logic [CONF_W-1:0]    conf_next;

    rr_arbiter4 u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    assign arb_idx = onehot_to_idx(arb_gnt);
    assign busy    = (state != ST_IDLE);

    always_comb begin
        feat_sel = '0;
        for (int i = 0; i < NUM_TRAYS; i++) begin
            if (arb_gnt[i]) feat_sel = tray_feat[i*FEAT_W +: FEAT_W];
        end
    end

    // Saturating confirm count for the tray being committed; a "not ready"
    // decision (including a timeout) restarts the streak.
    always_comb begin
        conf_cur  = conf_cnt[gidx];
        conf_next = '0;
        if (commit_dec) begin
            conf_next = (conf_cur == CONF_MAX) ? conf_cur : conf_cur + CONF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= 2'd0;
            gidx          <= 2'd0;
            grant         <= '0;
            cls_start     <= 1'b0;
            cls_feat      <= '0;
            result        <= '0;
            harvest_ready <= '0;
            timeout_err   <= 1'b0;
            wait_cnt      <= '0;
            commit_dec    <= 1'b0;
            for (int i = 0; i < NUM_TRAYS; i++) conf_cnt[i] <= '0;
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        state     <= ST_ISSUE;
                        grant     <= arb_gnt;
                        gidx      <= arb_idx;
                        rr_ptr    <= arb_idx + 2'd1;
                        cls_feat  <= feat_sel;
                        cls_start <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    cls_start <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the final WAIT cycle takes priority
                    // over the timeout.
                    if (cls_done) begin
                        commit_dec <= cls_result;
                        state      <= ST_COMMIT;
                    end else if (wait_cnt == TMO_LAST) begin
                        commit_dec  <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= ST_COMMIT;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    result[gidx]        <= commit_dec;
                    conf_cnt[gidx]      <= conf_next;
                    harvest_ready[gidx] <= (conf_next == CONF_MAX);
                    grant               <= '0;
                    state               <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bnn_tray_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bnn_tray_scheduler
//  Description : Directed self-checking bench for bnn_tray_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_tray_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [3:0]  req = 4'd0;
    logic [63:0] tray_feat;
    logic        cls_start;
    logic [15:0] cls_feat;
    logic        cls_done = 1'b0;
    logic        cls_result = 1'b0;
    logic [3:0]  grant;
    logic [3:0]  result;
    logic [3:0]  harvest_ready;
    logic        busy;
    logic        timeout_err;

    int ntests = 0;
    int nfail  = 0;

    logic [15:0] feat_tab [4] = '{16'h4321, 16'h8765, 16'hB2A1, 16'hD4C3};

    always #5 clk = ~clk;

    assign tray_feat = {feat_tab[3], feat_tab[2], feat_tab[1], feat_tab[0]};

    bnn_tray_scheduler #(.CONFIRM_N(3), .TIMEOUT(15)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .req           (req),
        .tray_feat     (tray_feat),
        .cls_start     (cls_start),
        .cls_feat      (cls_feat),
        .cls_done      (cls_done),
        .cls_result    (cls_result),
        .grant         (grant),
        .result        (result),
        .harvest_ready (harvest_ready),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    task automatic reset_dut();
        rst_n = 1'b0; ena = 1'b1; req = 4'd0; cls_done = 1'b0; cls_result = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one transaction. dly>0: cls_done is raised during WAIT cycle dly.
    // dly=0: no done. ena is dropped for ena_len cycles starting at cycle ena_at.
    // start_wait: negedges until cls_start seen (-1 if never).
    // cyc: negedges after the ISSUE sample until busy is observed low.
    task automatic run_txn(input int dly, input logic res, input int ena_at, input int ena_len,
                           output logic [3:0] g, output logic [15:0] f,
                           output int start_wait, output int cyc, output int extra_start);
        start_wait = 0; cyc = 0; extra_start = 0; g = 4'd0; f = 16'd0;
        while (cls_start !== 1'b1 && start_wait < 20) begin
            @(negedge clk);
            start_wait++;
        end
        if (cls_start !== 1'b1) begin
            start_wait = -1;
            return;
        end
        g = grant;
        f = cls_feat;
        while (cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (busy !== 1'b1) break;
            if (cls_start === 1'b1) extra_start++;
            cls_done   = (dly > 0 && cyc == dly);
            cls_result = res;
            ena        = !(ena_at > 0 && cyc >= ena_at && cyc < ena_at + ena_len);
        end
        cls_done = 1'b0;
        ena      = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        ntests++; if (grant !== 4'd0) begin nfail++; $display("FAIL reset_grant: got %b want 0000", grant); end
        ntests++; if (cls_start !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL reset_start_busy: got %b%b want 00", cls_start, busy); end
        ntests++; if (cls_feat !== 16'd0) begin nfail++; $display("FAIL reset_feat: got %h want 0000", cls_feat); end
        ntests++; if (result !== 4'd0 || harvest_ready !== 4'd0 || timeout_err !== 1'b0) begin
            nfail++; $display("FAIL reset_status: got res=%b hr=%b te=%b want 0000 0000 0", result, harvest_ready, timeout_err); end
        reset_dut();
    endtask

    task automatic test_single_tray();
        logic [3:0] g; logic [15:0] f; int sw, cyc, ex;
        reset_dut();
        req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            run_txn(2, 1'b1, 0, 0, g, f, sw, cyc, ex);
            ntests++; if (sw != 1) begin nfail++; $display("FAIL single_start_lat[%0d]: got %0d want 1", k, sw); end
            ntests++; if (g !== 4'b0001 || f !== feat_tab[0]) begin nfail++; $display("FAIL single_grant[%0d]: got %b/%h want 0001/%h", k, g, f, feat_tab[0]); end
            ntests++; if (cyc != 4 || ex != 0) begin nfail++; $display("FAIL single_len[%0d]: got cyc=%0d extra=%0d want 4/0", k, cyc, ex); end
            ntests++; if (result[0] !== 1'b1) begin nfail++; $display("FAIL single_result[%0d]: got %b want 1", k, result[0]); end
            ntests++; if (harvest_ready[0] !== (k == 2)) begin nfail++; $display("FAIL single_hr[%0d]: got %b want %0d", k, harvest_ready[0], k == 2); end
        end
        req = 4'b0000;
    endtask

    task automatic test_fairness();
        logic [3:0] g; logic [15:0] f; int sw, cyc, ex;
        logic [3:0] exp_g;
        reset_dut();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            run_txn(1, 1'b1, 0, 0, g, f, sw, cyc, ex);
            ntests++; if (g !== exp_g) begin nfail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, g, exp_g); end
            ntests++; if (f !== feat_tab[k % 4]) begin nfail++; $display("FAIL rr_feat[%0d]: got %h want %h", k, f, feat_tab[k % 4]); end
            ntests++; if (cyc != 3) begin nfail++; $display("FAIL rr_len[%0d]: got %0d want 3", k, cyc); end
        end
        req = 4'b0000;
        ntests++; if (result !== 4'b1111 || harvest_ready !== 4'b0000) begin
            nfail++; $display("FAIL rr_status: got res=%b hr=%b want 1111/0000", result, harvest_ready); end
    endtask

    task automatic test_timeout();
        logic [3:0] g; logic [15:0] f; int sw, cyc, ex;
        reset_dut();
        req = 4'b0100;
        run_txn(1, 1'b1, 0, 0, g, f, sw, cyc, ex);
        ntests++; if (result[2] !== 1'b1 || timeout_err !== 1'b0) begin
            nfail++; $display("FAIL to_pre: got res2=%b te=%b want 1/0", result[2], timeout_err); end
        run_txn(0, 1'b0, 0, 0, g, f, sw, cyc, ex);
        ntests++; if (g !== 4'b0100 || cyc != 17) begin nfail++; $display("FAIL to_len: got g=%b cyc=%0d want 0100/17", g, cyc); end
        ntests++; if (result[2] !== 1'b0 || timeout_err !== 1'b1) begin
            nfail++; $display("FAIL to_commit: got res2=%b te=%b want 0/1", result[2], timeout_err); end
        run_txn(2, 1'b1, 0, 0, g, f, sw, cyc, ex);
        req = 4'b0000;
        ntests++; if (result[2] !== 1'b1 || timeout_err !== 1'b1) begin
            nfail++; $display("FAIL to_sticky: got res2=%b te=%b want 1/1", result[2], timeout_err); end
    endtask

    task automatic test_confirm_reset();
        logic [3:0] g; logic [15:0] f; int sw, cyc, ex;
        logic [5:0] seq;
        seq = 6'b111011; // bit k = decision of commit k
        reset_dut();
        req = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            run_txn(1, seq[k], 0, 0, g, f, sw, cyc, ex);
            ntests++; if (result[1] !== seq[k]) begin nfail++; $display("FAIL conf_result[%0d]: got %b want %b", k, result[1], seq[k]); end
            ntests++; if (harvest_ready[1] !== (k == 5)) begin nfail++; $display("FAIL conf_hr[%0d]: got %b want %0d", k, harvest_ready[1], k == 5); end
        end
        req = 4'b0000;
    endtask

    task automatic test_boundary();
        logic [3:0] g; logic [15:0] f; int sw, cyc, ex;
        reset_dut();
        req = 4'b0001;
        run_txn(15, 1'b1, 0, 0, g, f, sw, cyc, ex);
        req = 4'b0000;
        ntests++; if (cyc != 17) begin nfail++; $display("FAIL edge_len: got %0d want 17", cyc); end
        ntests++; if (result[0] !== 1'b1 || timeout_err !== 1'b0) begin
            nfail++; $display("FAIL edge_done_wins: got res0=%b te=%b want 1/0", result[0], timeout_err); end
        cls_done = 1'b1; cls_result = 1'b0;
        @(negedge clk);
        cls_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ntests++; if (busy !== 1'b0 || grant !== 4'd0 || cls_start !== 1'b0 || result !== 4'b0001 || timeout_err !== 1'b0) begin
                nfail++; $display("FAIL stray_done[%0d]: got busy=%b g=%b st=%b res=%b te=%b want 0/0000/0/0001/0",
                                  k, busy, grant, cls_start, result, timeout_err); end
        end
    endtask

    task automatic test_reset_enable();
        logic [3:0] g; logic [15:0] f; int sw, cyc, ex;
        reset_dut();
        req = 4'b0001;
        run_txn(0, 1'b0, 3, 5, g, f, sw, cyc, ex);
        ntests++; if (cyc != 22) begin nfail++; $display("FAIL ena_hold_len: got %0d want 22", cyc); end
        ntests++; if (timeout_err !== 1'b1) begin nfail++; $display("FAIL ena_hold_te: got %b want 1", timeout_err); end
        run_txn(1, 1'b1, 0, 0, g, f, sw, cyc, ex);
        ntests++; if (result[0] !== 1'b1) begin nfail++; $display("FAIL rst_pre: got %b want 1", result[0]); end
        // Next grant: ISSUE then two WAIT cycles, then reset mid-wait.
        repeat (3) @(negedge clk);
        ntests++; if (busy !== 1'b1 || cls_start !== 1'b0) begin nfail++; $display("FAIL rst_in_wait: got busy=%b st=%b want 1/0", busy, cls_start); end
        rst_n = 1'b0;
        #1;
        ntests++; if (grant !== 4'd0 || busy !== 1'b0 || cls_feat !== 16'd0 || cls_start !== 1'b0) begin
            nfail++; $display("FAIL rst_mid_ctrl: got g=%b busy=%b feat=%h st=%b want 0000/0/0000/0", grant, busy, cls_feat, cls_start); end
        ntests++; if (result !== 4'd0 || harvest_ready !== 4'd0 || timeout_err !== 1'b0) begin
            nfail++; $display("FAIL rst_mid_status: got res=%b hr=%b te=%b want 0000/0000/0", result, harvest_ready, timeout_err); end
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_tray();
        test_fairness();
        test_timeout();
        test_confirm_reset();
        test_boundary();
        test_reset_enable();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", ntests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
